// File: rtl/sr_level_driver_if.sv
// Command/feedback bundle between a level-command source and sr_level_driver.
// master = command source side, slave = sr_level_driver side.
interface sr_level_driver_if #(
    parameter int unsigned CNT_W = 8
) ();
    logic             cmd_valid;
    logic             cmd_level;
    logic             cmd_ready;
    logic             q_fb;
    logic             err_clr;
    logic             S;
    logic             R;
    logic             busy;
    logic             err;
    logic [CNT_W-1:0] pulse_cnt;

    modport master (
        output cmd_valid, cmd_level, q_fb, err_clr,
        input  cmd_ready, S, R, busy, err, pulse_cnt
    );

    modport slave (
        input  cmd_valid, cmd_level, q_fb, err_clr,
        output cmd_ready, S, R, busy, err, pulse_cnt
    );
endinterface

// File: rtl/sr_level_driver.sv
// Turns absolute Q-level commands into single S/R toggle pulses for a T-style SR flop,
// buffering commands in a small FIFO and verifying the fed-back Q after each pulse.
module sr_level_driver #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    sr_level_driver_if.slave bus
);
    localparam int unsigned    PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_CMP    = 2'd1;
    localparam logic [1:0] ST_PULSE  = 2'd2;
    localparam logic [1:0] ST_VERIFY = 2'd3;

    logic [DEPTH-1:0] r_mem;
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [PTR_W:0]   r_count;
    logic [1:0]       r_state;
    logic             r_tgt;
    logic             r_s;
    logic             r_r;
    logic             r_err;
    logic [CNT_W-1:0] r_pulse_cnt;

    logic [1:0] w_state_nxt;
    logic       w_full;
    logic       w_empty;
    logic       w_push;
    logic       w_pop;
    logic       w_mismatch;

    assign w_full     = (r_count == FULL_CNT);
    assign w_empty    = (r_count == '0);
    assign w_push     = bus.cmd_valid && !w_full;
    // Pop decision uses only registered state, so a fresh push is seen one cycle later.
    assign w_pop      = (r_state == ST_IDLE) && !w_empty;
    assign w_mismatch = (bus.q_fb != r_tgt);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= bus.cmd_level;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
                2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   w_state_nxt = w_empty ? ST_IDLE : ST_CMP;
            ST_CMP:    w_state_nxt = w_mismatch ? ST_PULSE : ST_IDLE;
            ST_PULSE:  w_state_nxt = ST_VERIFY;
            ST_VERIFY: w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_tgt       <= 1'b0;
            r_s         <= 1'b0;
            r_r         <= 1'b0;
            r_err       <= 1'b0;
            r_pulse_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_pop) begin
                r_tgt <= r_mem[r_rptr];
            end
            // S/R are complementary when issued, so hold is never commanded.
            r_s <= 1'b0;
            r_r <= 1'b0;
            if (r_state == ST_CMP && w_mismatch) begin
                r_s         <= r_tgt;
                r_r         <= !r_tgt;
                r_pulse_cnt <= r_pulse_cnt + CNT_W'(1);
            end
            if (r_state == ST_VERIFY && w_mismatch) begin
                r_err <= 1'b1;
            end else if (bus.err_clr) begin
                r_err <= 1'b0;
            end
        end
    end

    assign bus.cmd_ready = !w_full;
    assign bus.S         = r_s;
    assign bus.R         = r_r;
    assign bus.busy      = (r_state != ST_IDLE) || !w_empty;
    assign bus.err       = r_err;
    assign bus.pulse_cnt = r_pulse_cnt;
endmodule

// File: tb/tb_sr_level_driver.sv
// Bench for sr_level_driver: behavioural T-style SR flop in the loop, pulse scoreboard,
// table-driven command sequences and hand-timed corner cases.
module tb_sr_level_driver;
    localparam int unsigned DEPTH = 4;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic q     = 1'b0;
    logic q2    = 1'b0;
    logic stuck = 1'b0;
    int   n_checks = 0;
    int   n_err    = 0;
    logic [1:0] sb[$];

    typedef struct {
        logic       level;
        logic [1:0] pulse;
        logic [7:0] cnt;
    } vec_t;

    vec_t t_seq[4];
    vec_t t_fill[6];
    vec_t t_wrap[5];

    sr_level_driver_if #(.CNT_W(8)) bus ();
    sr_level_driver_if #(.CNT_W(2)) bus2 ();

    sr_level_driver #(.DEPTH(DEPTH), .CNT_W(8)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    sr_level_driver #(.DEPTH(DEPTH), .CNT_W(2)) u_dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    always #5 clk = ~clk;

    // Flop model: S alone or R alone toggles Q; not affected by rst.
    assign bus.q_fb  = stuck ? 1'b0 : q;
    assign bus2.q_fb = q2;
    always @(posedge clk) begin
        if (bus.S ^ bus.R) q <= ~q;
        if (bus2.S ^ bus2.R) q2 <= ~q2;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Every observed pulse must match the next expected one, one cycle each.
    always @(negedge clk) begin
        if (!rst) begin
            chk("s_and_r_dut", 32'(bus.S & bus.R), 0);
            chk("s_and_r_dut2", 32'(bus2.S & bus2.R), 0);
            if (bus.S || bus.R) begin
                if (sb.size() == 0) begin
                    chk("unexpected_pulse", 32'({bus.S, bus.R}), 0);
                end else begin
                    chk("pulse_kind", 32'({bus.S, bus.R}), 32'(sb.pop_front()));
                end
            end
        end
    end

    task automatic push(input logic lvl, input logic [1:0] exp, input bit chk_rdy);
        bus.cmd_valid = 1'b1;
        bus.cmd_level = lvl;
        if (chk_rdy) chk("ready_high", 32'(bus.cmd_ready), 1);
        for (int i = 0; i < 100 && !bus.cmd_ready; i++) @(negedge clk);
        if (!bus.cmd_ready) chk("push_timeout", 32'(bus.cmd_ready), 1);
        if (exp != 2'b00) sb.push_back(exp);
        @(negedge clk);
    endtask

    task automatic push2(input logic lvl);
        bus2.cmd_valid = 1'b1;
        bus2.cmd_level = lvl;
        for (int i = 0; i < 100 && !bus2.cmd_ready; i++) @(negedge clk);
        if (!bus2.cmd_ready) chk("push2_timeout", 32'(bus2.cmd_ready), 1);
        @(negedge clk);
        bus2.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input bit sel, input string name);
        for (int i = 0; i < 100 && (sel ? bus2.busy : bus.busy); i++) @(negedge clk);
        chk(name, 32'(sel ? bus2.busy : bus.busy), 0);
    endtask

    task automatic do_reset();
        #1 rst = 1'b1;
        #1 chk("rst_ready", 32'(bus.cmd_ready), 1);
        repeat (2) @(negedge clk);
        sb.delete();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        t_seq[0]  = '{1'b1, 2'b10, 8'd0};
        t_seq[1]  = '{1'b1, 2'b00, 8'd0};
        t_seq[2]  = '{1'b0, 2'b01, 8'd0};
        t_seq[3]  = '{1'b0, 2'b00, 8'd0};
        t_fill[0] = '{1'b1, 2'b10, 8'd0};
        t_fill[1] = '{1'b0, 2'b01, 8'd0};
        t_fill[2] = '{1'b1, 2'b10, 8'd0};
        t_fill[3] = '{1'b0, 2'b01, 8'd0};
        t_fill[4] = '{1'b1, 2'b10, 8'd0};
        t_fill[5] = '{1'b0, 2'b01, 8'd0};
        t_wrap[0] = '{1'b1, 2'b10, 8'd1};
        t_wrap[1] = '{1'b0, 2'b01, 8'd2};
        t_wrap[2] = '{1'b1, 2'b10, 8'd3};
        t_wrap[3] = '{1'b0, 2'b01, 8'd0};
        t_wrap[4] = '{1'b1, 2'b10, 8'd1};

        bus.cmd_valid  = 1'b0;
        bus.cmd_level  = 1'b0;
        bus.err_clr    = 1'b0;
        bus2.cmd_valid = 1'b0;
        bus2.cmd_level = 1'b0;
        bus2.err_clr   = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_ready_init", 32'(bus.cmd_ready), 1);
        chk("rst_s", 32'(bus.S), 0);
        chk("rst_r", 32'(bus.R), 0);
        chk("rst_err", 32'(bus.err), 0);
        chk("rst_cnt", 32'(bus.pulse_cnt), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        @(negedge clk);
        rst = 1'b0;

        // Single set: S exactly in cycle 3 after the push edge
        push(1'b1, 2'b10, 1'b1);
        bus.cmd_valid = 1'b0;
        chk("t1_s_c1", 32'(bus.S), 0);
        @(negedge clk);
        chk("t1_s_c2", 32'(bus.S), 0);
        @(negedge clk);
        chk("t1_s_c3", 32'(bus.S), 1);
        chk("t1_r_c3", 32'(bus.R), 0);
        @(negedge clk);
        chk("t1_s_c4", 32'(bus.S), 0);
        chk("t1_qfb_verify", 32'(bus.q_fb), 1);
        @(negedge clk);
        chk("t1_err", 32'(bus.err), 0);
        chk("t1_busy", 32'(bus.busy), 0);
        chk("t1_cnt", 32'(bus.pulse_cnt), 1);
        push(1'b0, 2'b01, 1'b1);
        bus.cmd_valid = 1'b0;
        wait_idle(1'b0, "t1b_drain");
        chk("t1b_q", 32'(bus.q_fb), 0);
        do_reset();

        // Back-to-back 1,1,0,0 from Q = 0
        for (int i = 0; i < 4; i++) push(t_seq[i].level, t_seq[i].pulse, 1'b1);
        bus.cmd_valid = 1'b0;
        chk("t2_busy", 32'(bus.busy), 1);
        wait_idle(1'b0, "t2_drain");
        chk("t2_cnt", 32'(bus.pulse_cnt), 2);
        chk("t2_sb_empty", 32'(sb.size()), 0);
        chk("t2_q", 32'(bus.q_fb), 0);
        do_reset();

        // Fill past DEPTH behind a stalled FSM
        for (int i = 0; i < 6; i++) begin
            push(t_fill[i].level, t_fill[i].pulse, 1'b0);
            if (i == DEPTH) chk("t3_full", 32'(bus.cmd_ready), 0);
        end
        bus.cmd_valid = 1'b0;
        wait_idle(1'b0, "t3_drain");
        chk("t3_cnt", 32'(bus.pulse_cnt), 6);
        chk("t3_sb_empty", 32'(sb.size()), 0);
        chk("t3_q", 32'(bus.q_fb), 0);
        do_reset();

        // Verify failure with q_fb stuck at 0
        stuck = 1'b1;
        push(1'b1, 2'b10, 1'b1);
        bus.cmd_valid = 1'b0;
        wait_idle(1'b0, "t4_drain_a");
        chk("t4_err_set", 32'(bus.err), 1);
        repeat (3) @(negedge clk);
        chk("t4_err_sticky", 32'(bus.err), 1);
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
        chk("t4_err_clr", 32'(bus.err), 0);
        push(1'b1, 2'b10, 1'b1);
        bus.cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
        chk("t4_set_wins", 32'(bus.err), 1);
        wait_idle(1'b0, "t4_drain_b");
        stuck = 1'b0;
        chk("t4_cnt", 32'(bus.pulse_cnt), 2);
        do_reset();

        // Reset asserted during PULSE with commands queued
        push(1'b1, 2'b10, 1'b1);
        push(1'b0, 2'b01, 1'b1);
        push(1'b1, 2'b10, 1'b1);
        bus.cmd_valid = 1'b0;
        chk("t5_s_pulse", 32'(bus.S), 1);
        #1 rst = 1'b1;
        #1;
        chk("t5_s_drop", 32'(bus.S), 0);
        chk("t5_r_drop", 32'(bus.R), 0);
        chk("t5_busy", 32'(bus.busy), 0);
        chk("t5_ready", 32'(bus.cmd_ready), 1);
        chk("t5_cnt", 32'(bus.pulse_cnt), 0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("t5_fifo_empty", 32'(bus.busy), 0);
        chk("t5_q_kept", 32'(bus.q_fb), 0);

        // CNT_W = 2 wrap with alternating levels
        for (int i = 0; i < 5; i++) begin
            push2(t_wrap[i].level);
            wait_idle(1'b1, "t6_drain");
            chk("t6_cnt", 32'(bus2.pulse_cnt), 32'(t_wrap[i].cnt));
        end
        chk("t6_q", 32'(q2), 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/sr_level_driver.md
# sr_level_driver

Upstream command stage for the T-based SR flop (S alone or R alone toggles Q, S and R together hold). It accepts target-level commands on a valid/ready interface, buffers them in a small FIFO, and compares each target against the flop's fed-back Q. It issues a single one-cycle S or R pulse only when Q must change, then verifies the result. The caller can therefore request absolute levels without tracking the flop's toggle semantics.

## Interface
- DEPTH, 4: command FIFO depth; power of two, ≥2.
- CNT_W, 8: width of the issued-pulse counter.
- clk  in  1  rising-edge clock, shared with the SR flop.
- rst  in  1  reset, asynchronous and active-high.
- cmd_valid  in  1  command present.
- cmd_level  in  1  requested Q level.
- cmd_ready  out  1  FIFO not full.
- q_fb  in  1  Q from the downstream SR flop.
- err_clr  in  1  synchronous clear of err.
- S  out  1  registered set pulse to the flop.
- R  out  1  registered reset pulse to the flop.
- busy  out  1  FSM not in IDLE, or FIFO non-empty.
- err  out  1  sticky verify failure.
- pulse_cnt  out  CNT_W  count of issued S/R pulses.

## Operation
- FIFO push:
  - Occurs when cmd_valid && cmd_ready.
  - cmd_ready = !full; it depends only on the registered count.
  - A push while full is impossible by construction; no overflow state exists.
- FIFO pointers are log2(DEPTH) bits and wrap naturally. A separate count register, 0..DEPTH, gives full/empty.
- FSM states:
  - IDLE: if the FIFO is non-empty, pop the head into tgt and go to CMP; otherwise stay in IDLE.
  - CMP:
    - If q_fb == tgt, go to IDLE with no pulse.
    - Otherwise, at the same edge, load S ← tgt and R ← !tgt, increment pulse_cnt, and go to PULSE.
  - PULSE: S/R are high this cycle and the flop toggles at the closing edge. Clear S and R to 0 at that edge and go to VERIFY.
  - VERIFY: if q_fb != tgt, set err. Go to IDLE.
- S and R are never high simultaneously. That would command hold, and the block never needs it.
- At most one of S/R is high, and only in the PULSE state.
- pulse_cnt wraps modulo 2^CNT_W and has no saturation.
- err clearing:
  - err_clr clears err at the clock edge.
  - If err_clr and a VERIFY failure coincide, set wins.
- The FIFO is popped only from IDLE, based on the registered count. A push to an empty FIFO is therefore popped no earlier than the following cycle.
- Simultaneous push and pop in the same cycle is legal. The count is unchanged and the pointers both advance.

## Timing
- Reset (async assert):
  - State = IDLE, FIFO empty.
  - S = 0, R = 0, err = 0, pulse_cnt = 0, busy = 0.
  - cmd_ready = 1 throughout reset.
- Reset mid-operation aborts immediately: S/R drop in the same cycle and queued commands are discarded. The flop has no reset, so Q is not restored.
- Latency, counting cycle 0 as the push edge:
  - Pop at edge 1 at the earliest, CMP in cycle 2.
  - If a change is needed, S or R is high during cycle 3 and Q changes at the end of cycle 3.
  - VERIFY is in cycle 4, and IDLE returns in cycle 5.
- Per-command occupancy: 2 cycles when no change is needed (IDLE→CMP→IDLE), 4 cycles when a change is needed.
- q_fb is sampled only in CMP and VERIFY. It must be the flop's registered Q with no combinational path back to S/R.
- busy is combinational from state and count.

## Test plan
- Reset, then push level 1 with q_fb = 0 → S high for exactly one cycle (cycle 3), R = 0, q_fb = 1 in VERIFY, err = 0, pulse_cnt = 1.
- Push the levels 1, 1, 0, 0 back-to-back starting from Q = 0 → cmd_ready stays high, exactly two pulses (S then R), pulse_cnt = 2, busy falls after the last command.
- Push DEPTH + 1 commands while the FSM is stalled behind a pulse → cmd_ready = 0 after DEPTH entries, no command is lost, and all commands execute in order.
- Force q_fb stuck at 0 and push level 1 → err = 1 after VERIFY and stays set. Pulse err_clr → err = 0. Assert err_clr in the same cycle as a failing VERIFY → err = 1.
- Assert rst during PULSE → S/R go to 0 immediately, FIFO empty, pulse_cnt = 0, cmd_ready = 1.
- With CNT_W = 2, issue 5 alternating-level commands → pulse_cnt wraps 3→0→1, and S & R is never high in any cycle (assert every cycle).
